// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-register definitions: NOP encoding and the IF/ID payload layout.
// No logic, so no latency.
// No handshake of its own; used by the IF/ID, ID/EX and EX/MEM stage registers.
package cpu_pipe_pkg;

    localparam int PC_W_DEF    = 64;
    localparam int INSTR_W_DEF = 32;

    // addi x0, x0, 0: architecturally a no-op, shown to decode whenever nothing is valid
    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_stage_reg_if.sv
// Fetch->decode link carried through the IF/ID stage register: input side and output side.
// Wires only, no latency.
// Valid/ready on both sides; the stage drives in_ready and out_valid.
interface if_id_stage_reg_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic [ADDR_W-1:0]  in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;

    // Environment view: fetch drives the input side, decode drives out_ready
    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    // Stage-register view
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/pipe_slot.sv
// One valid bit plus payload register with load and clear.
// Load/clear take effect on the next rising edge.
// No handshake; the owner decides when to load or clear (clear wins over load).
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Valid flag: clear has priority so a flush always empties the slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     valid <= 1'b0;
        else if (clear) valid <= 1'b0;
        else if (load)  valid <= 1'b1;
    end

    // Payload only moves on load; stale data is simply ignored while invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF->ID pipeline register with a one-entry skid slot and a bubble counter.
// 1 cycle from input accept to out_valid; full 1/cycle throughput.
// in_ready is !skid_valid straight from a flop; it drops one cycle after a stall captures into skid.
module if_id_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                 ADDR_W    = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_ENC),
    parameter int                 PERF_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    if_id_stage_reg_if.slave  bus,
    output logic [PERF_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } payload_t;

    payload_t in_d, main_d, main_q, skid_q;
    logic     main_valid, skid_valid;
    logic     main_load, main_clr, main_from_skid;
    logic     skid_load, skid_clr;
    logic     in_fire, out_fire;

    assign in_d     = '{pc: bus.in_pc, instr: bus.in_instr};
    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = main_valid & bus.out_ready;

    // Slot control: flush first, then the drain/refill/capture cases in priority order
    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (!main_valid) begin
            main_load = in_fire;
        end else if (out_fire && skid_valid) begin
            // skid is older than anything on the input, so it refills main first
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
        end else if (out_fire) begin
            main_load = in_fire;
            main_clr  = !in_fire;
        end else if (in_fire) begin
            // decode stalled while fetch delivered: park it in skid
            skid_load = 1'b1;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_d;

    pipe_slot #(.W($bits(payload_t))) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    pipe_slot #(.W($bits(payload_t))) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_d),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_pc    = main_q.pc;
    assign bus.out_instr = main_valid ? main_q.instr : NOP_INSTR;

    // Bubble counter: decode ready but nothing to give it; saturates, survives flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bubble_cnt <= '0;
        else if (!main_valid && bus.out_ready && (bubble_cnt != {PERF_W{1'b1}}))
            bubble_cnt <= bubble_cnt + 1'b1;
    end

endmodule
